// File: rtl/ins_fetch_queue_if.sv
// ============================================================================
// ins_fetch_queue_if : fetch-queue bus (control, cache port, decode port)
// Revision 1.0
// ============================================================================
`default_nettype none

interface ins_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              en;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic [DATA_W-1:0] ic_data;
  logic              ins_valid;
  logic [DATA_W-1:0] ins_out;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_ready;
  logic [CNT_W-1:0]  count;

  // master: the fetch queue itself
  modport master (
    input  en, flush, flush_pc, ic_ack, ic_data, ins_ready,
    output ic_req, ic_addr, ins_valid, ins_out, ins_pc, count
  );

  // slave: the surrounding pipeline and instruction cache
  modport slave (
    output en, flush, flush_pc, ic_ack, ic_data, ins_ready,
    input  ic_req, ic_addr, ins_valid, ins_out, ins_pc, count
  );
endinterface

`default_nettype wire

// File: rtl/ins_fetch_queue.sv
// ============================================================================
// ins_fetch_queue : fetch PC owner, cache requester and instruction FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module ins_fetch_queue #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  ins_fetch_queue_if.master   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t             state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               ic_req_q;
  logic [ADDR_W-1:0]  ic_addr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [DATA_W-1:0]  data_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];

  logic               ins_valid;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   count_d;
  logic               space;
  logic [ADDR_W-1:0]  pc_inc;

  assign ins_valid = (count_q != '0);
  assign push      = (state_q == S_WAIT) && bus.ic_ack && !bus.flush;
  assign pop       = ins_valid && bus.ins_ready && !bus.flush;
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  // A new request only issues once the previous one has completed, so the
  // outstanding term is always zero at the decision point.
  assign space     = (count_d < CNT_W'(DEPTH));
  assign pc_inc    = pc_q + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ic_req_q  <= 1'b0;
      ic_addr_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else if (bus.flush) begin
      pc_q     <= bus.flush_pc;
      ic_req_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Any request still unanswered must have its ack swallowed later.
      state_q  <= (state_q != S_IDLE && !bus.ic_ack) ? S_DROP : S_IDLE;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case (state_q)
        S_IDLE: begin
          if (bus.en && space) begin
            ic_req_q  <= 1'b1;
            ic_addr_q <= pc_q;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.ic_ack) begin
            pc_q <= pc_inc;
            if (bus.en && space) begin
              ic_addr_q <= pc_inc;
            end else begin
              ic_req_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (bus.ic_ack) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset; the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= bus.ic_data;
      pc_mem_q[wr_ptr_q]   <= pc_q;
    end
  end

  assign bus.ic_req    = ic_req_q;
  assign bus.ic_addr   = ic_addr_q;
  assign bus.count     = count_q;
  assign bus.ins_valid = ins_valid;
  assign bus.ins_out   = ins_valid ? data_mem_q[rd_ptr_q] : '0;
  assign bus.ins_pc    = ins_valid ? pc_mem_q[rd_ptr_q]   : '0;

endmodule

`default_nettype wire
